// File: rtl/qu_res_st_issue_sched.sv
// Round-robin issue scheduler for the reservation station: selects one ready entry per cycle.
// Optional perf counters are enabled by defining QU_ISSUE_SCHED_PERF_CNT_EN.
module qu_res_st_issue_sched #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic [DEPTH-1:0]  busy_i,
   input  logic [DEPTH-1:0]  src_rdy_i,
   output logic              issue_valid_o,
   input  logic              issue_ready_i,
   output logic [ADDR_W-1:0] issue_idx_o,
   output logic              issue_clr_o,
   output logic [ADDR_W-1:0] issue_clr_idx_o
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]       perf_issued_o,
   output logic [31:0]       perf_stall_o
`endif
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] rr_q, rr_d;
   logic              clr_q, clr_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
   logic [DEPTH-1:0]  pending_q, pending_d;

   logic [DEPTH-1:0]  hold_mask;
   logic [DEPTH-1:0]  elig;
   logic [DEPTH-1:0]  elig_hi;
   logic              hs;
   logic              load;
   logic              any_hi, any_lo;
   logic [ADDR_W-1:0] win_hi, win_lo;
   logic              grant;
   logic [ADDR_W-1:0] winner;
   logic [ADDR_W-1:0] rr_next;

   // Eligibility and round-robin pick: prefer the lowest eligible index at or above rr_q, else wrap.
   always_comb begin
      hold_mask = '0;
      if (valid_q) begin
         hold_mask[idx_q] = 1'b1;
      end
      elig    = busy_i & src_rdy_i & ~pending_q & ~hold_mask;
      elig_hi = elig & ~((DEPTH'(1) << rr_q) - DEPTH'(1));
      hs      = valid_q & issue_ready_i;
      load    = ~valid_q | hs;

      any_hi = 1'b0;
      any_lo = 1'b0;
      win_hi = '0;
      win_lo = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            any_lo = 1'b1;
            win_lo = ADDR_W'(i);
         end
         if (elig_hi[i]) begin
            any_hi = 1'b1;
            win_hi = ADDR_W'(i);
         end
      end
      grant   = any_lo;
      winner  = any_hi ? win_hi : win_lo;
      rr_next = (winner == ADDR_W'(DEPTH - 1)) ? '0 : winner + ADDR_W'(1);
   end

   // Next-state: handshake marks the entry pending and pulses the clear; flush overrides everything.
   always_comb begin
      valid_d   = valid_q;
      idx_d     = idx_q;
      rr_d      = rr_q;
      clr_d     = 1'b0;
      clr_idx_d = clr_idx_q;
      pending_d = pending_q & busy_i;

      if (hs) begin
         pending_d[idx_q] = 1'b1;
         clr_d            = 1'b1;
         clr_idx_d        = idx_q;
      end

      if (load) begin
         if (grant) begin
            valid_d = 1'b1;
            idx_d   = winner;
            rr_d    = rr_next;
         end else begin
            valid_d = 1'b0;
         end
      end

      if (flush_i) begin
         valid_d   = 1'b0;
         pending_d = '0;
         rr_d      = '0;
         clr_d     = 1'b0;
         clr_idx_d = clr_idx_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         idx_q     <= '0;
         rr_q      <= '0;
         clr_q     <= 1'b0;
         clr_idx_q <= '0;
         pending_q <= '0;
      end else begin
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         rr_q      <= rr_d;
         clr_q     <= clr_d;
         clr_idx_q <= clr_idx_d;
         pending_q <= pending_d;
      end
   end

   assign issue_valid_o   = valid_q;
   assign issue_idx_o     = idx_q;
   assign issue_clr_o     = clr_q;
   assign issue_clr_idx_o = clr_idx_q;

`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
   logic [31:0] issued_q, issued_d;
   logic [31:0] stall_q, stall_d;

   // Counters survive flush and wrap naturally at 2^32.
   always_comb begin
      issued_d = issued_q + {31'd0, hs};
      stall_d  = stall_q + {31'd0, valid_q & ~issue_ready_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign perf_issued_o = issued_q;
   assign perf_stall_o  = stall_q;
`endif

   a_valid_entry_busy: assert property (@(posedge clk) disable iff (!rst_n)
      (issue_valid_o && !flush_i) |-> busy_i[issue_idx_o]);

endmodule

// File: tb/tb_qu_res_st_issue_sched.sv
// Directed testbench for qu_res_st_issue_sched: reset, single issue, round robin,
// backpressure, operand wait, flush and async reset scenarios.
module tb_qu_res_st_issue_sched;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst_n;
   logic              flush_i;
   logic [DEPTH-1:0]  busy_i;
   logic [DEPTH-1:0]  src_rdy_i;
   logic              issue_valid_o;
   logic              issue_ready_i;
   logic [ADDR_W-1:0] issue_idx_o;
   logic              issue_clr_o;
   logic [ADDR_W-1:0] issue_clr_idx_o;
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
   logic [31:0]       perf_issued_o;
   logic [31:0]       perf_stall_o;
`endif

   int vectors = 0;
   int errors  = 0;

   qu_res_st_issue_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush_i         (flush_i),
      .busy_i          (busy_i),
      .src_rdy_i       (src_rdy_i),
      .issue_valid_o   (issue_valid_o),
      .issue_ready_i   (issue_ready_i),
      .issue_idx_o     (issue_idx_o),
      .issue_clr_o     (issue_clr_o),
      .issue_clr_idx_o (issue_clr_idx_o)
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
      ,
      .perf_issued_o   (perf_issued_o),
      .perf_stall_o    (perf_stall_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      busy_i        = '0;
      src_rdy_i     = '0;
      issue_ready_i = 1'b0;
      flush_i       = 1'b0;
      rst_n         = 1'b0;
      #3;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; flush_i = 1'b0; busy_i = '0; src_rdy_i = '0; issue_ready_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", issue_valid_o); end
      vectors++; if (issue_idx_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", issue_idx_o); end
      vectors++; if (issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr: got %b expected 0", issue_clr_o); end
      vectors++; if (issue_clr_idx_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_clr_idx: got %0d expected 0", issue_clr_idx_o); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++; if (issue_valid_o !== 1'b0 || issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_empty: got valid=%b clr=%b expected 0 0", issue_valid_o, issue_clr_o); end
      end
   endtask

   task automatic test_single_entry();
      do_reset();
      busy_i[5] = 1'b1; src_rdy_i[5] = 1'b1; issue_ready_i = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd5) begin errors++; $display("[TB] FAIL single_issue: got valid=%b idx=%0d expected 1 5", issue_valid_o, issue_idx_o); end
      vectors++; if (issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL single_no_early_clr: got %b expected 0", issue_clr_o); end
      step();
      vectors++; if (issue_clr_o !== 1'b1 || issue_clr_idx_o !== 5'd5) begin errors++; $display("[TB] FAIL single_clr: got clr=%b idx=%0d expected 1 5", issue_clr_o, issue_clr_idx_o); end
      vectors++; if (issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_no_regrant: got %b expected 0", issue_valid_o); end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++; if (issue_valid_o !== 1'b0 || issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL single_masked: got valid=%b clr=%b expected 0 0", issue_valid_o, issue_clr_o); end
      end
      busy_i = '0; src_rdy_i = '0;
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      issue_ready_i = 1'b1;
      busy_i[2] = 1'b1; busy_i[7] = 1'b1; busy_i[30] = 1'b1;
      src_rdy_i = busy_i;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd2) begin errors++; $display("[TB] FAIL rr_first: got valid=%b idx=%0d expected 1 2", issue_valid_o, issue_idx_o); end
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd7) begin errors++; $display("[TB] FAIL rr_second: got valid=%b idx=%0d expected 1 7", issue_valid_o, issue_idx_o); end
      vectors++; if (issue_clr_o !== 1'b1 || issue_clr_idx_o !== 5'd2) begin errors++; $display("[TB] FAIL rr_clr2: got clr=%b idx=%0d expected 1 2", issue_clr_o, issue_clr_idx_o); end
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd30) begin errors++; $display("[TB] FAIL rr_third: got valid=%b idx=%0d expected 1 30", issue_valid_o, issue_idx_o); end
      vectors++; if (issue_clr_idx_o !== 5'd7) begin errors++; $display("[TB] FAIL rr_clr7: got %0d expected 7", issue_clr_idx_o); end
      busy_i = '0; busy_i[30] = 1'b1; src_rdy_i = busy_i;
      step();
      vectors++; if (issue_valid_o !== 1'b0 || issue_clr_idx_o !== 5'd30) begin errors++; $display("[TB] FAIL rr_drain: got valid=%b clr_idx=%0d expected 0 30", issue_valid_o, issue_clr_idx_o); end
      busy_i = '0; busy_i[2] = 1'b1; busy_i[31] = 1'b1; src_rdy_i = busy_i;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd31) begin errors++; $display("[TB] FAIL rr_wrap31: got valid=%b idx=%0d expected 1 31", issue_valid_o, issue_idx_o); end
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd2) begin errors++; $display("[TB] FAIL rr_wrap2: got valid=%b idx=%0d expected 1 2", issue_valid_o, issue_idx_o); end
      step();
      vectors++; if (issue_valid_o !== 1'b0 || issue_clr_idx_o !== 5'd2) begin errors++; $display("[TB] FAIL rr_end: got valid=%b clr_idx=%0d expected 0 2", issue_valid_o, issue_clr_idx_o); end
      busy_i = '0; src_rdy_i = '0;
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      busy_i[3] = 1'b1; src_rdy_i[3] = 1'b1; issue_ready_i = 1'b0;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd3) begin errors++; $display("[TB] FAIL bp_grant: got valid=%b idx=%0d expected 1 3", issue_valid_o, issue_idx_o); end
      busy_i[9] = 1'b1; src_rdy_i[9] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd3) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b idx=%0d expected 1 3", issue_valid_o, issue_idx_o); end
      end
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
      vectors++; if (perf_stall_o !== 32'd4) begin errors++; $display("[TB] FAIL bp_stall_cnt: got %0d expected 4", perf_stall_o); end
`endif
      issue_ready_i = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd9) begin errors++; $display("[TB] FAIL bp_next: got valid=%b idx=%0d expected 1 9", issue_valid_o, issue_idx_o); end
      vectors++; if (issue_clr_o !== 1'b1 || issue_clr_idx_o !== 5'd3) begin errors++; $display("[TB] FAIL bp_clr: got clr=%b idx=%0d expected 1 3", issue_clr_o, issue_clr_idx_o); end
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
      vectors++; if (perf_issued_o !== 32'd1) begin errors++; $display("[TB] FAIL bp_issued_cnt: got %0d expected 1", perf_issued_o); end
`endif
      step();
      vectors++; if (issue_valid_o !== 1'b0 || issue_clr_idx_o !== 5'd9) begin errors++; $display("[TB] FAIL bp_end: got valid=%b clr_idx=%0d expected 0 9", issue_valid_o, issue_clr_idx_o); end
      busy_i = '0; src_rdy_i = '0;
      step();
   endtask

   task automatic test_operand_wait();
      do_reset();
      busy_i[12] = 1'b1; issue_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++; if (issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL opwait_idle: got %b expected 0", issue_valid_o); end
      end
      src_rdy_i[12] = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd12) begin errors++; $display("[TB] FAIL opwait_issue: got valid=%b idx=%0d expected 1 12", issue_valid_o, issue_idx_o); end
      step();
      vectors++; if (issue_clr_o !== 1'b1 || issue_clr_idx_o !== 5'd12) begin errors++; $display("[TB] FAIL opwait_clr: got clr=%b idx=%0d expected 1 12", issue_clr_o, issue_clr_idx_o); end
      busy_i = '0; src_rdy_i = '0;
      step();
   endtask

   task automatic test_flush();
      do_reset();
      busy_i[4] = 1'b1; src_rdy_i[4] = 1'b1; issue_ready_i = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd4) begin errors++; $display("[TB] FAIL flush_pre: got valid=%b idx=%0d expected 1 4", issue_valid_o, issue_idx_o); end
      flush_i = 1'b1;
      step();
      vectors++; if (issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_clr: got %b expected 0", issue_clr_o); end
      vectors++; if (issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", issue_valid_o); end
      flush_i = 1'b0;
      busy_i[6] = 1'b1; src_rdy_i[6] = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd4) begin errors++; $display("[TB] FAIL flush_regrant: got valid=%b idx=%0d expected 1 4", issue_valid_o, issue_idx_o); end
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd6) begin errors++; $display("[TB] FAIL flush_follow: got valid=%b idx=%0d expected 1 6", issue_valid_o, issue_idx_o); end
      vectors++; if (issue_clr_o !== 1'b1 || issue_clr_idx_o !== 5'd4) begin errors++; $display("[TB] FAIL flush_clr4: got clr=%b idx=%0d expected 1 4", issue_clr_o, issue_clr_idx_o); end
      flush_i = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b0 || issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_second: got valid=%b clr=%b expected 0 0", issue_valid_o, issue_clr_o); end
      flush_i = 1'b0; busy_i = '0; src_rdy_i = '0;
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      busy_i[3] = 1'b1; src_rdy_i[3] = 1'b1; issue_ready_i = 1'b0;
      step();
      step();
      vectors++; if (issue_valid_o !== 1'b1 || issue_idx_o !== 5'd3) begin errors++; $display("[TB] FAIL areset_hold: got valid=%b idx=%0d expected 1 3", issue_valid_o, issue_idx_o); end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (issue_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", issue_valid_o); end
      vectors++; if (issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_clr: got %b expected 0", issue_clr_o); end
`ifdef QU_ISSUE_SCHED_PERF_CNT_EN
      vectors++; if (perf_stall_o !== 32'd0 || perf_issued_o !== 32'd0) begin errors++; $display("[TB] FAIL areset_perf: got stall=%0d issued=%0d expected 0 0", perf_stall_o, perf_issued_o); end
`endif
      busy_i = '0; src_rdy_i = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      vectors++; if (issue_valid_o !== 1'b0 || issue_clr_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_after: got valid=%b clr=%b expected 0 0", issue_valid_o, issue_clr_o); end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_round_robin();
      test_backpressure();
      test_operand_wait();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
